tone_rom_sequencer: RTL and testbench
=====================================

Name: tone_rom_sequencer

Overview:
- Drives the address of the tone sample ROM (128 x 32-bit, combinational read) and turns its output into a sample stream with a valid/ready handshake toward the I2S transmit path.
- Steps one table entry per sample-rate strobe, wraps at the table period, and flags a sample request it could not service because the previous sample was not yet taken.
- Sits between the tone ROM (upstream) and the I2S TX sample interface (downstream).

Parameters:
- DATA_WIDTH, 32, sample width; must match the ROM word width.
- ADDR_WIDTH, 7, ROM address width.
- TABLE_LEN, 109, number of valid ROM entries in one tone period; range 2 to 2**ADDR_WIDTH.

Ports:
- clk_i  in  1  single clock; the whole block runs on it.
- rst_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  playback enable.
- restart_i  in  1  one-cycle pulse that forces the phase back to address 0.
- sample_req_i  in  1  one-cycle strobe at the sample rate from the I2S side.
- rom_addr_o  out  ADDR_WIDTH  registered ROM address.
- rom_q_i  in  DATA_WIDTH  ROM read data, combinational from rom_addr_o.
- sample_o  out  DATA_WIDTH  registered sample.
- sample_valid_o  out  1  sample_o holds an untaken sample.
- sample_ready_i  in  1  consumer accepts the sample.
- overrun_o  out  1  sticky flag: a request was dropped.
- overrun_clr_i  in  1  clears overrun_o.

Behaviour:
- Reset values (rst_i high at a clock edge): state IDLE, rom_addr_o=0, sample_o=0, sample_valid_o=0, overrun_o=0. Reset wins over every other input, including mid-handshake.
- FSM states and transitions:
  - IDLE → FETCH on sample_req_i & enable_i.
  - FETCH lasts exactly 1 cycle; it lets rom_q_i settle from the stable rom_addr_o. At the end of FETCH: sample_o <= rom_q_i, sample_valid_o <= 1, rom_addr_o advances, next state HOLD.
  - HOLD: sample_valid_o stays high and sample_o stays stable until sample_valid_o & sample_ready_i at a clock edge. On that edge, clear valid and go to IDLE.
- Latency: strobe in cycle N (state IDLE) → FETCH in cycle N+1 → sample_valid_o high in cycle N+2. A consumer that is always ready holds valid for exactly 1 cycle.
- Address advance: if rom_addr_o == TABLE_LEN-1 the next value is 0, otherwise rom_addr_o+1. Addresses at or above TABLE_LEN are never produced.
- restart_i:
  - Sets rom_addr_o=0 on the next edge in any state.
  - In FETCH, restart takes priority over the advance: the fetched sample is the old address, and the next address is 0.
  - Does not disturb a sample already held in HOLD.
- enable_i low:
  - Requests arriving in IDLE are ignored and do not set overrun.
  - A FETCH or HOLD already in progress completes normally.
  - Phase is retained across disable/enable.
- Overrun: sample_req_i & enable_i while in FETCH or HOLD sets overrun_o; the request is dropped and the address does not advance. Exception: in HOLD, if the handshake completes in the same cycle as the request, the request is accepted and the next state is FETCH, not IDLE.
- overrun_clr_i: if a set and a clear occur in the same cycle, set wins.
- Arithmetic: unsigned address compare against TABLE_LEN-1 truncated to ADDR_WIDTH. The sample data is passed through untouched unless the optional feature is enabled.

Optional Feature:
- Macro: TONE_ROM_SEQUENCER_ATTEN_EN.
- Defined:
  - Adds input atten_i [3:0].
  - The value captured at the end of FETCH is rom_q_i arithmetically right-shifted (sign-extended) by atten_i, sampled in the FETCH cycle.
  - atten_i=0 gives pass-through; atten_i=15 leaves only sign plus upper bits.
- Undefined: atten_i port absent; the ROM word is captured unmodified.

Decomposition:
- Shared package `tone_seq_pkg`:
  - FSM state encoding constants ST_IDLE, ST_FETCH, ST_HOLD (2 bits).
  - Default DATA_WIDTH, ADDR_WIDTH, TABLE_LEN constants reused by the ROM and the testbench.
- Sub-module `tone_phase_counter`: the wrapping address counter with advance, restart and hold inputs. It is small and separately testable. Everything else stays in the top level.

Test Plan:
- Reset/first sample: ROM preloaded with entry i = i, strobe in cycle 10, ready tied high → sample_valid_o high only in cycle 12, sample_o=0, rom_addr_o=1 afterwards, overrun_o=0.
- Wrap: TABLE_LEN=109, 110 strobes spaced 8 cycles, ready high → samples 0..108 then 0; rom_addr_o never exceeds 108.
- Backpressure/overrun: ready low for 20 cycles across 2 strobes → sample 0 held stable, overrun_o=1, second strobe dropped; on ready, the next strobe yields sample 1. overrun_clr_i then clears the flag, and a simultaneous set keeps it at 1.
- Handshake + request same cycle: in HOLD, assert ready and sample_req_i together → valid drops, FETCH follows, next sample is address+1, overrun_o stays 0.
- Restart/disable: restart_i pulsed during FETCH of address 50 → sample 50 delivered, next sample is 0. enable_i low for 3 strobes → no samples and no overrun; phase resumes at the same address.
- Reset mid-HOLD: rst_i high while valid is held → valid=0, addr=0 on the next edge. With TONE_ROM_SEQUENCER_ATTEN_EN and atten_i=4: ROM word 32'h8000_0000 → sample_o 32'hF800_0000.

Source files
------------

// File: rtl/tone_seq_pkg.sv
// Shared state encoding and default geometry for the tone ROM sequencer,
// its phase counter and anything that models the tone ROM.
package tone_seq_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 7;
    localparam int unsigned DEF_TABLE_LEN  = 109;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } tone_state_e;

endpackage

// File: rtl/tone_phase_counter.sv
// Wrapping tone-table address counter: steps on advance, snaps to 0 on
// restart and otherwise holds its value.
module tone_phase_counter
    import tone_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned TABLE_LEN  = DEF_TABLE_LEN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  advance_i,
    input  logic                  restart_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TABLE_LEN - 1);

    logic [ADDR_WIDTH-1:0] addr_d, addr_q;

    // Restart outranks advance so a restart during a fetch lands on 0.
    always_comb begin
        addr_d = addr_q;
        if (restart_i) begin
            addr_d = '0;
        end else if (advance_i) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/tone_rom_sequencer.sv
// Turns tone ROM words into a valid/ready sample stream, one entry per sample
// strobe. Define TONE_ROM_SEQUENCER_ATTEN_EN to add the atten_i shift stage.
module tone_rom_sequencer
    import tone_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned TABLE_LEN  = DEF_TABLE_LEN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  restart_i,
    input  logic                  sample_req_i,
`ifdef TONE_ROM_SEQUENCER_ATTEN_EN
    input  logic [3:0]            atten_i,
`endif
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_q_i,
    output logic [DATA_WIDTH-1:0] sample_o,
    output logic                  sample_valid_o,
    input  logic                  sample_ready_i,
    output logic                  overrun_o,
    input  logic                  overrun_clr_i
);

    tone_state_e           state_d, state_q;
    logic [DATA_WIDTH-1:0] sample_d, sample_q;
    logic                  valid_d, valid_q;
    logic                  overrun_d, overrun_q;
    logic [DATA_WIDTH-1:0] captured;
    logic                  req;
    logic                  handshake;
    logic                  overrun_set;

    assign req       = sample_req_i & enable_i;
    assign handshake = valid_q & sample_ready_i;

`ifdef TONE_ROM_SEQUENCER_ATTEN_EN
    assign captured = $signed(rom_q_i) >>> atten_i;
`else
    assign captured = rom_q_i;
`endif

    // A request is only serviceable in IDLE, or in HOLD when the sample is
    // being taken on the same edge.
    assign overrun_set = req & ((state_q == ST_FETCH) | ((state_q == ST_HOLD) & ~handshake));

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                sample_d = captured;
                valid_d  = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    state_d = req ? ST_FETCH : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        overrun_d = overrun_q;
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    tone_phase_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .TABLE_LEN  (TABLE_LEN)
    ) u_phase (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance_i (state_q == ST_FETCH),
        .restart_i (restart_i),
        .addr_o    (rom_addr_o)
    );

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_tone_rom_sequencer.sv
// Directed and randomized bench for tone_rom_sequencer against a
// transaction-level phase/sample model. Honours TONE_ROM_SEQUENCER_ATTEN_EN.
module tb_tone_rom_sequencer;
    import tone_seq_pkg::*;

    localparam int TL = DEF_TABLE_LEN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        restart = 1'b0;
    logic        sample_req = 1'b0;
    logic [6:0]  rom_addr;
    logic [31:0] rom_q;
    logic [31:0] sample;
    logic        valid;
    logic        ready = 1'b1;
    logic        overrun;
    logic        overrun_clr = 1'b0;
`ifdef TONE_ROM_SEQUENCER_ATTEN_EN
    logic [3:0]  atten = 4'd0;
`endif

    logic [31:0] rom [128];
    assign rom_q = rom[rom_addr];

    int n_checks = 0;
    int n_fail   = 0;
    int phase    = 0;

    always #5 clk = ~clk;

    tone_rom_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .restart_i      (restart),
        .sample_req_i   (sample_req),
`ifdef TONE_ROM_SEQUENCER_ATTEN_EN
        .atten_i        (atten),
`endif
        .rom_addr_o     (rom_addr),
        .rom_q_i        (rom_q),
        .sample_o       (sample),
        .sample_valid_o (valid),
        .sample_ready_i (ready),
        .overrun_o      (overrun),
        .overrun_clr_i  (overrun_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_sample(input logic [31:0] w);
`ifdef TONE_ROM_SEQUENCER_ATTEN_EN
        return $signed(w) >>> atten;
`else
        return w;
`endif
    endfunction

    function automatic int next_phase(input int p);
        return (p + 1) % TL;
    endfunction

    // One full transaction from IDLE: strobe, fetch, hold for `delay` cycles, take.
    task automatic fetch_one(input int delay, input logic exp_ovr);
        logic [31:0] exp_s;
        exp_s = model_sample(rom[phase]);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        chk("fetch_no_valid", 32'(valid), 32'd0);
        tick();
        chk("valid_rise", 32'(valid), 32'd1);
        chk("sample", sample, exp_s);
        phase = next_phase(phase);
        chk("addr_adv", 32'(rom_addr), 32'(phase));
        chk("addr_range", 32'(rom_addr < 7'(TL)), 32'd1);
        ready = (delay == 0);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("hold_valid", 32'(valid), 32'd1);
            chk("hold_stable", sample, exp_s);
            if (i == delay - 1) ready = 1'b1;
        end
        tick();
        chk("valid_fall", 32'(valid), 32'd0);
        chk("overrun_state", 32'(overrun), 32'(exp_ovr));
    endtask

    initial begin
        logic [31:0] exp_s;
        for (int i = 0; i < 128; i++) rom[i] = 32'(i);

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_sample", sample, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // First sample, strobe around cycle 10
        repeat (7) tick();
        fetch_one(0, 1'b0);

        // Wrap across the table period
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_idle_addr", 32'(rom_addr), 32'd0);
        phase = 0;
        for (int n = 0; n < 110; n++) begin
            fetch_one(0, 1'b0);
            repeat (5) tick();
        end
        chk("wrap_phase", 32'(rom_addr), 32'd1);

        // Backpressure and overrun
        exp_s = model_sample(rom[phase]);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        chk("bp_valid", 32'(valid), 32'd1);
        chk("bp_sample", sample, exp_s);
        phase = next_phase(phase);
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample_req = (i == 5);
            tick();
            chk("bp_hold_valid", 32'(valid), 32'd1);
            chk("bp_hold_sample", sample, exp_s);
            chk("bp_addr_frozen", 32'(rom_addr), 32'(phase));
            chk("bp_overrun", 32'(overrun), 32'(i >= 5));
        end
        sample_req = 1'b0;
        ready = 1'b1;
        tick();
        chk("bp_release", 32'(valid), 32'd0);
        fetch_one(0, 1'b1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'd0);

        // Set and clear in the same cycle: set wins
        exp_s = model_sample(rom[phase]);
        sample_req = 1'b1;
        tick();
        overrun_clr = 1'b1;
        tick();
        sample_req = 1'b0;
        overrun_clr = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        chk("ovr_sample", sample, exp_s);
        phase = next_phase(phase);
        tick();
        chk("ovr_take", 32'(valid), 32'd0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clear2", 32'(overrun), 32'd0);

        // Handshake and request in the same cycle
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        ready = 1'b0;
        tick();
        phase = next_phase(phase);
        tick();
        chk("hs_hold", 32'(valid), 32'd1);
        ready = 1'b1;
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        chk("hs_valid_drop", 32'(valid), 32'd0);
        chk("hs_no_overrun", 32'(overrun), 32'd0);
        tick();
        chk("hs_refetch", 32'(valid), 32'd1);
        chk("hs_sample", sample, model_sample(rom[phase]));
        phase = next_phase(phase);
        chk("hs_addr", 32'(rom_addr), 32'(phase));
        tick();
        chk("hs_take", 32'(valid), 32'd0);

        // Restart during the FETCH of address 50
        restart = 1'b1;
        tick();
        restart = 1'b0;
        phase = 0;
        for (int n = 0; n < 50; n++) fetch_one(0, 1'b0);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_sample50", sample, model_sample(rom[50]));
        chk("rs_addr0", 32'(rom_addr), 32'd0);
        phase = 0;
        tick();
        fetch_one(0, 1'b0);

        // Restart during HOLD leaves the held sample alone
        exp_s = model_sample(rom[phase]);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        ready = 1'b0;
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rsh_valid", 32'(valid), 32'd1);
        chk("rsh_sample", sample, exp_s);
        chk("rsh_addr", 32'(rom_addr), 32'd0);
        phase = 0;
        ready = 1'b1;
        tick();

        // Disabled strobes are ignored; phase retained
        fetch_one(0, 1'b0);
        enable = 1'b0;
        repeat (3) begin
            sample_req = 1'b1;
            tick();
            sample_req = 1'b0;
            repeat (3) tick();
            chk("dis_valid", 32'(valid), 32'd0);
            chk("dis_overrun", 32'(overrun), 32'd0);
            chk("dis_addr", 32'(rom_addr), 32'(phase));
        end
        enable = 1'b1;
        fetch_one(0, 1'b0);

        // A FETCH in flight completes after enable drops
        exp_s = model_sample(rom[phase]);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        enable = 1'b0;
        tick();
        chk("dis_fetch_valid", 32'(valid), 32'd1);
        chk("dis_fetch_sample", sample, exp_s);
        phase = next_phase(phase);
        tick();
        enable = 1'b1;

        // Reset in the middle of HOLD
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b1;
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_addr", 32'(rom_addr), 32'd0);
        chk("mid_rst_sample", sample, 32'd0);
        phase = 0;

`ifdef TONE_ROM_SEQUENCER_ATTEN_EN
        atten = 4'd4;
        rom[phase] = 32'h8000_0000;
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        chk("atten_shift", sample, 32'hF800_0000);
        phase = next_phase(phase);
        tick();
        atten = 4'd0;
`endif

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            rom[phase] = $urandom;
`ifdef TONE_ROM_SEQUENCER_ATTEN_EN
            atten = 4'($urandom_range(0, 15));
`endif
            repeat ($urandom_range(0, 4)) tick();
            if ($urandom_range(0, 3) != 0) begin
                fetch_one(int'($urandom_range(0, 4)), 1'b0);
            end else begin
                enable = 1'b0;
                sample_req = 1'b1;
                tick();
                sample_req = 1'b0;
                repeat (2) tick();
                chk("rnd_dis_valid", 32'(valid), 32'd0);
                chk("rnd_dis_addr", 32'(rom_addr), 32'(phase));
                enable = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
